// File: rtl/cb_rdata_deskew_pkg.sv
// Shared CB package: default geometry and beat-mode encoding for the read-data
// deskew path and the address-skew generator.
package cb_rdata_deskew_pkg;

  // Default number of CB banks (lanes).
  localparam int CB_LANES   = 4;
  // Default data width per bank.
  localparam int CB_DATA_W  = 64;
  // Default number of beats that make up one row.
  localparam int CB_ROW_LEN = 10;

  // Beat mode carried by group_cnt_0 when lane 0 starts a beat.
  typedef enum logic {
    MODE_SKEW  = 1'b0,
    MODE_ALIGN = 1'b1
  } cb_mode_e;

  // One entry of the per-beat token pipeline.
  typedef struct packed {
    logic     valid;
    cb_mode_e mode;
  } cb_token_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cb_lane_delay.sv
// Parameterised delay line of depth D for one lane entry (valid bit + data).
// D = 0 degenerates to a plain wire.
module cb_lane_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic [W-1:0] data,
  output logic [W-1:0] delayed
);

  if (D == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ sys_rst;
    assign delayed        = data;
  end else begin : g_pipe
    logic [W-1:0] stage [D];

    // Shift the entry one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
      if (sys_rst) begin
        for (int i = 0; i < D; i++) stage[i] <= '0;
      end else begin
        stage[0] <= data;
        for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
      end
    end

    assign delayed = stage[D-1];
  end

endmodule

// File: rtl/cb_rdata_deskew.sv
// CB read-data deskew: realigns per-bank read beats (skewed by one cycle per
// lane, or already aligned) into full rows with a fixed latency of L cycles.
module cb_rdata_deskew
  import cb_rdata_deskew_pkg::*;
#(
  parameter int L       = CB_LANES,
  parameter int CB_DW   = CB_DATA_W,
  parameter int ROW_LEN = CB_ROW_LEN
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic [L-1:0]       CB_en,
  input  logic               group_cnt_0,
  input  logic [CB_DW*L-1:0] din,
  output logic [CB_DW*L-1:0] dout,
  output logic               dout_valid,
  output logic [L-1:0]       dout_mask,
  output logic               dout_last,
  output logic               busy,
  output logic               coll_err
);

  localparam int            CW       = cnt_width(ROW_LEN);
  localparam int            EW       = CB_DW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROW_LEN - 1);

  // tok[k] holds the beat that started k+1 cycles ago.
  cb_token_t          tok [L];
  logic [L-1:0]       tok_valid;
  logic               start;
  cb_mode_e           start_mode;
  logic               align_start;
  logic [L-1:0]       skew_claim;
  logic [L-1:0]       lane_err;
  logic [EW-1:0]      lane_out [L];
  logic [CB_DW*L-1:0] lane_data;
  logic [L-1:0]       lane_mask;
  logic [CB_DW*L-1:0] dout_q;
  logic [L-1:0]       mask_q;
  logic [CW-1:0]      row_cnt;
  logic               err_q;
  logic               unused_tail_mode;

  assign start            = CB_en[0];
  assign start_mode       = cb_mode_e'(group_cnt_0);
  assign align_start      = start && (start_mode == MODE_ALIGN);
  assign unused_tail_mode = tok[L-1].mode;

  // Token pipeline: one entry per cycle records whether a beat started and its mode.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int k = 0; k < L; k++) tok[k] <= '0;
    end else begin
      tok[0].valid <= start;
      tok[0].mode  <= start_mode;
      for (int k = 1; k < L; k++) tok[k] <= tok[k-1];
    end
  end

  // Per lane j: the beat owning this lane's skewed slot this cycle started j
  // cycles ago. Aligned data is captured at the beat start and pre-delayed by j
  // so both modes meet the same slot, then a common D = L-1-j line lines every
  // lane up for the output register.
  for (genvar j = 0; j < L; j++) begin : g_lane
    logic             slot_v;
    cb_mode_e         slot_m;
    logic [CB_DW-1:0] lane_din;
    logic             al_v;
    logic             sk_v;
    logic [EW-1:0]    al_entry;
    logic [EW-1:0]    al_dly;
    logic [EW-1:0]    sk_entry;
    logic [EW-1:0]    slot_entry;

    assign tok_valid[j] = tok[j].valid;

    if (j == 0) begin : g_first
      assign slot_v = start;
      assign slot_m = start_mode;
    end else begin : g_rest
      assign slot_v = tok[j-1].valid;
      assign slot_m = tok[j-1].mode;
    end

    assign lane_din      = din[j*CB_DW +: CB_DW];
    assign skew_claim[j] = slot_v && (slot_m == MODE_SKEW);

    // A skewed claim always wins the lane; a colliding aligned lane is dropped.
    assign sk_v     = skew_claim[j] && CB_en[j];
    assign al_v     = align_start && CB_en[j] && !skew_claim[j];
    assign sk_entry = sk_v ? {1'b1, lane_din} : '0;
    assign al_entry = al_v ? {1'b1, lane_din} : '0;

    // Error when both modes claim the lane, or when nobody claims it.
    assign lane_err[j] = CB_en[j] && (skew_claim[j] == align_start);

    cb_lane_delay #(
      .W (EW),
      .D (j)
    ) u_align_dly (
      .clk     (clk),
      .sys_rst (sys_rst),
      .data    (al_entry),
      .delayed (al_dly)
    );

    assign slot_entry = (slot_v && (slot_m == MODE_ALIGN)) ? al_dly : sk_entry;

    cb_lane_delay #(
      .W (EW),
      .D (L - 1 - j)
    ) u_lane_dly (
      .clk     (clk),
      .sys_rst (sys_rst),
      .data    (slot_entry),
      .delayed (lane_out[j])
    );

    assign lane_data[j*CB_DW +: CB_DW] = lane_out[j][CB_DW-1:0];
    assign lane_mask[j]                = lane_out[j][CB_DW];
  end

  // Output register: captures the fully assembled beat one cycle before it is shown.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      dout_q <= '0;
      mask_q <= '0;
    end else begin
      dout_q <= lane_data;
      mask_q <= lane_mask;
    end
  end

  // Row counter: advances on every presented beat and wraps after the last one.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      row_cnt <= '0;
    end else if (tok[L-1].valid) begin
      row_cnt <= (row_cnt == LAST_CNT) ? '0 : row_cnt + 1'b1;
    end
  end

  // Sticky collision/orphan flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      err_q <= 1'b0;
    end else if (|lane_err) begin
      err_q <= 1'b1;
    end
  end

  assign dout_valid = tok[L-1].valid && !sys_rst;
  assign dout       = dout_valid ? dout_q : '0;
  assign dout_mask  = dout_valid ? mask_q : '0;
  assign dout_last  = dout_valid && (row_cnt == LAST_CNT);
  assign busy       = (|tok_valid) && !sys_rst;
  assign coll_err   = err_q && !sys_rst;

endmodule

// File: tb/tb_cb_rdata_deskew.sv
// Self-checking bench for cb_rdata_deskew: directed scenarios plus random
// segments, compared each cycle against a per-beat reference model.
module tb_cb_rdata_deskew;

  localparam int L    = 4;
  localparam int DW   = 64;
  localparam int RL   = 10;
  localparam int MAXC = 48;
  localparam int MAXH = MAXC + L + 2;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic [L-1:0]    CB_en;
  logic            group_cnt_0;
  logic [DW*L-1:0] din;
  logic [DW*L-1:0] dout;
  logic            dout_valid;
  logic [L-1:0]    dout_mask;
  logic            dout_last;
  logic            busy;
  logic            coll_err;

  int tests     = 0;
  int fails     = 0;
  int cur_cycle = 0;
  int seg_n     = 0;

  logic [L-1:0]    en_a  [MAXC];
  logic            md_a  [MAXC];
  logic [DW-1:0]   dd_a  [MAXC][L];

  logic            exp_valid [MAXH];
  logic            exp_last  [MAXH];
  logic            exp_busy  [MAXH];
  logic            exp_err   [MAXH];
  logic [L-1:0]    exp_mask  [MAXH];
  logic [DW*L-1:0] exp_dout  [MAXH];

  always #5 clk = ~clk;

  cb_rdata_deskew #(
    .L       (L),
    .CB_DW   (DW),
    .ROW_LEN (RL)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .CB_en       (CB_en),
    .group_cnt_0 (group_cnt_0),
    .din         (din),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_mask   (dout_mask),
    .dout_last   (dout_last),
    .busy        (busy),
    .coll_err    (coll_err)
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cur_cycle, got, exp);
    end
  endtask

  function automatic bit enAt(input int c, input int j);
    if (c < 0 || c >= seg_n) return 1'b0;
    return en_a[c][j];
  endfunction

  function automatic bit isSkewBeat(input int s);
    if (s < 0 || s >= seg_n) return 1'b0;
    return en_a[s][0] && !md_a[s];
  endfunction

  // Reference model: walk the beats in start order and build each output beat
  // directly from the lane-capture rules; errors become visible one cycle later.
  task automatic computeExpected();
    int k;
    bit acc;
    bit sk;
    bit al;
    for (int c = 0; c < MAXH; c++) begin
      exp_valid[c] = 1'b0;
      exp_last[c]  = 1'b0;
      exp_busy[c]  = 1'b0;
      exp_err[c]   = 1'b0;
      exp_mask[c]  = '0;
      exp_dout[c]  = '0;
    end
    k = 0;
    for (int s = 0; s < seg_n; s++) begin
      if (en_a[s][0]) begin
        exp_valid[s+L] = 1'b1;
        exp_last[s+L]  = ((k % RL) == RL - 1);
        k++;
        for (int c = s + 1; c <= s + L; c++) exp_busy[c] = 1'b1;
        for (int j = 0; j < L; j++) begin
          if (!md_a[s]) begin
            if (enAt(s + j, j)) begin
              exp_mask[s+L][j]            = 1'b1;
              exp_dout[s+L][j*DW +: DW]   = dd_a[s+j][j];
            end
          end else if (en_a[s][j] && !(j > 0 && isSkewBeat(s - j))) begin
            exp_mask[s+L][j]              = 1'b1;
            exp_dout[s+L][j*DW +: DW]     = dd_a[s][j];
          end
        end
      end
    end
    acc = 1'b0;
    for (int c = 0; c < MAXH; c++) begin
      exp_err[c] = acc;
      for (int j = 1; j < L; j++) begin
        if (enAt(c, j)) begin
          sk = isSkewBeat(c - j);
          al = enAt(c, 0) && md_a[c];
          if ((sk && al) || (!sk && !al)) acc = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int c);
    if (c < seg_n) begin
      CB_en       = en_a[c];
      group_cnt_0 = md_a[c];
      for (int j = 0; j < L; j++) din[j*DW +: DW] = dd_a[c][j];
    end else begin
      CB_en       = '0;
      group_cnt_0 = 1'b0;
      din         = '0;
    end
  endtask

  task automatic clearStim(input int n);
    seg_n = n;
    for (int c = 0; c < MAXC; c++) begin
      en_a[c] = '0;
      md_a[c] = 1'b0;
      for (int j = 0; j < L; j++) dd_a[c][j] = {$urandom(), $urandom()};
    end
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    sys_rst     = 1'b1;
    CB_en       = '0;
    group_cnt_0 = 1'b0;
    din         = '0;
    repeat (2) begin
      @(negedge clk);
      cur_cycle = -1;
      checkOutput("rst_valid", 256'(dout_valid), 256'(0));
      checkOutput("rst_dout",  256'(dout),       256'(0));
      checkOutput("rst_mask",  256'(dout_mask),  256'(0));
      checkOutput("rst_last",  256'(dout_last),  256'(0));
      checkOutput("rst_busy",  256'(busy),       256'(0));
      checkOutput("rst_err",   256'(coll_err),   256'(0));
    end
  endtask

  task automatic runSegment(input bit do_reset);
    computeExpected();
    if (do_reset) resetDut();
    for (int c = 0; c <= seg_n + L + 1; c++) begin
      @(posedge clk);
      #1;
      sys_rst = 1'b0;
      applyStimulus(c);
      cur_cycle = c;
      @(negedge clk);
      checkOutput("valid",    256'(dout_valid), 256'(exp_valid[c]));
      checkOutput("dout",     256'(dout),       256'(exp_dout[c]));
      checkOutput("mask",     256'(dout_mask),  256'(exp_mask[c]));
      checkOutput("last",     256'(dout_last),  256'(exp_last[c]));
      checkOutput("busy",     256'(busy),       256'(exp_busy[c]));
      checkOutput("coll_err", 256'(coll_err),   256'(exp_err[c]));
    end
  endtask

  task automatic fillSkewTrain(input int beats);
    clearStim(beats + L - 1);
    for (int c = 0; c < seg_n; c++)
      for (int j = 0; j < L; j++)
        if (c - j >= 0 && c - j < beats) en_a[c][j] = 1'b1;
  endtask

  // Reset lands on cycle 2 of a skewed beat; nothing of it may surface later.
  task automatic midBeatReset();
    @(posedge clk); #1;
    sys_rst = 1'b0; CB_en = 4'b0001; group_cnt_0 = 1'b0; din = {4{$urandom(), $urandom()}};
    cur_cycle = 0;
    @(negedge clk);
    checkOutput("mid_valid_t0", 256'(dout_valid), 256'(0));
    @(posedge clk); #1;
    CB_en = 4'b0010;
    cur_cycle = 1;
    @(negedge clk);
    checkOutput("mid_busy_t1", 256'(busy), 256'(1));
    @(posedge clk); #1;
    sys_rst = 1'b1; CB_en = '0;
    cur_cycle = 2;
    @(negedge clk);
    checkOutput("mid_busy_t2", 256'(busy), 256'(0));
    @(posedge clk); #1;
    sys_rst = 1'b0;
    cur_cycle = 3;
    @(negedge clk);
    checkOutput("mid_busy_t3", 256'(busy), 256'(0));
    for (int c = 4; c < 8; c++) begin
      @(posedge clk); #1;
      cur_cycle = c;
      @(negedge clk);
      checkOutput("mid_valid", 256'(dout_valid), 256'(0));
      checkOutput("mid_busy",  256'(busy),       256'(0));
      checkOutput("mid_err",   256'(coll_err),   256'(0));
    end
  endtask

  initial begin
    bit sk;
    bit al;
    sys_rst     = 1'b1;
    CB_en       = '0;
    group_cnt_0 = 1'b0;
    din         = '0;

    // Single skewed beat, lanes 0x10..0x13.
    clearStim(4);
    for (int j = 0; j < L; j++) begin
      en_a[j][j] = 1'b1;
      dd_a[j][j] = 64'h10 + 64'(j);
    end
    runSegment(1'b1);

    // Aligned beat, lanes 0xA0..0xA3.
    clearStim(1);
    en_a[0] = 4'hF;
    md_a[0] = 1'b1;
    for (int j = 0; j < L; j++) dd_a[0][j] = 64'hA0 + 64'(j);
    runSegment(1'b1);

    // Row wrap: 11 back-to-back skewed beats.
    fillSkewTrain(11);
    runSegment(1'b1);

    // Collision: skewed beat then aligned beat with all lanes.
    clearStim(4);
    en_a[0] = 4'b0001;
    en_a[1] = 4'hF;
    md_a[1] = 1'b1;
    en_a[2] = 4'b0100;
    en_a[3] = 4'b1000;
    runSegment(1'b1);

    // Partial skewed beat with lane 2 withheld.
    clearStim(4);
    en_a[0] = 4'b0001;
    en_a[1] = 4'b0010;
    en_a[3] = 4'b1000;
    runSegment(1'b1);

    // Advance the row counter, reset mid-beat, then a fresh row must wrap on its 10th beat.
    fillSkewTrain(3);
    runSegment(1'b1);
    midBeatReset();
    fillSkewTrain(11);
    runSegment(1'b0);

    // Random segments: mostly well-formed traffic with occasional drops and orphans.
    for (int r = 0; r < 10; r++) begin
      clearStim(40);
      for (int c = 0; c < seg_n; c++) begin
        en_a[c][0] = 1'($urandom_range(0, 1));
        md_a[c]    = 1'($urandom_range(0, 1));
        for (int j = 1; j < L; j++) begin
          sk = isSkewBeat(c - j);
          al = en_a[c][0] && md_a[c];
          if (sk || al) en_a[c][j] = ($urandom_range(0, 9) != 0);
          else          en_a[c][j] = ($urandom_range(0, 19) == 0);
        end
      end
      runSegment(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cb_rdata_deskew.md
CB_RDATA_DESKEW -- requirements
Module: cb_rdata_deskew

Interface
REQ-001 Parameter L, default 4, number of CB banks (lanes); L >= 2.
REQ-002 Parameter CB_DW, default 64, data width per bank.
REQ-003 Parameter ROW_LEN, default 10, beats per row.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 sys_rst  input  1  synchronous, active-high reset.
REQ-006 CB_en  input  L  per-bank read-data-valid; bit j qualifies lane j of din.
REQ-007 group_cnt_0  input  1  mode tag, sampled only when CB_en[0]=1: 0 = skewed beat, 1 = aligned beat.
REQ-008 din  input  CB_DW*L  bank read data; lane j at bits [j*CB_DW +: CB_DW].
REQ-009 dout  output  CB_DW*L  realigned row data, lane order as din.
REQ-010 dout_valid  output  1  one-cycle strobe per realigned beat.
REQ-011 dout_mask  output  L  lanes of dout that carried valid data in the beat.
REQ-012 dout_last  output  1  high with dout_valid on beat ROW_LEN-1 of a row.
REQ-013 busy  output  1  high while any beat is in flight.
REQ-014 coll_err  output  1  sticky lane-collision flag.

Function
REQ-015 Beat start: a beat starts at cycle t when CB_en[0]=1; its mode is group_cnt_0 at t.
REQ-016 Skewed-beat lanes: lane j of a skewed beat is taken from din at cycle t+j, when CB_en[j]=1.
REQ-017 Aligned-beat lanes: lane j of an aligned beat is taken from din at cycle t, when CB_en[j]=1.
REQ-018 Latency: the block SHALL assert dout_valid for a beat started at t exactly at cycle t+L, in both modes, so output order equals start order.
REQ-019 Missing lanes: a lane whose CB_en bit is 0 at its capture cycle SHALL output zero data and a 0 in dout_mask.
REQ-020 Collision: when lane j at cycle c is claimed both by a skewed beat (started c-j, j>0) and by an aligned beat (started c), the data SHALL go to the skewed beat, the aligned lane SHALL be zero and masked, and coll_err SHALL set.
REQ-021 Orphan lanes: CB_en[j]=1 (j>0) with no beat claiming lane j SHALL be ignored and SHALL set coll_err.
REQ-022 Back-to-back beats: one beat start per cycle SHALL be supported with no bubbles.
REQ-023 Row counter: a beat counter SHALL count output beats 0..ROW_LEN-1; dout_last SHALL be asserted at count ROW_LEN-1; the counter SHALL then wrap to 0.
REQ-024 Idle outputs: when dout_valid=0, dout and dout_mask SHALL be 0 and dout_last SHALL be 0.
REQ-025 busy: SHALL be high from the cycle after a beat start until its dout_valid cycle, inclusive.
REQ-026 Backpressure: none; the consumer SHALL accept every dout_valid.
REQ-027 Latched state: the block SHALL keep a per-beat token pipeline of depth L, each entry holding a valid bit and a mode bit.
REQ-028 Lane storage: the block SHALL keep per-lane holding registers that accumulate each in-flight beat.

Reset
REQ-029 While sys_rst=1, the block SHALL produce dout=0, dout_mask=0, dout_valid=0, dout_last=0, busy=0 and coll_err=0.
REQ-030 While sys_rst=1, the token pipeline and the row counter SHALL be cleared.
REQ-031 Reset mid-beat: a reset asserted during a beat SHALL discard all in-flight beats; no dout_valid SHALL appear for them after reset release.
REQ-032 coll_err SHALL clear only on sys_rst.

Structure
REQ-033 Shared package: the defaults for L, CB_DW and ROW_LEN and the mode encoding (SKEW=0, ALIGN=1) SHALL live in the shared CB package used with the CB address-skew generator.
REQ-034 Sub-module: one sub-module, cb_lane_delay (a parameterised per-lane delay line of depth D), SHALL be instantiated per lane with D = L-1-j in skewed mode.

Verification
REQ-035 Scenario, single skewed beat: L=4, CB_en[0] at t=0 with group_cnt_0=0, then CB_en[j] at t=j with din lane j = 0x10+j -> at t=4: dout_valid=1, dout lanes = 0x10,0x11,0x12,0x13, dout_mask=4'hF.
REQ-036 Scenario, aligned beat: CB_en=4'hF at t=0 with group_cnt_0=1 and lanes 0xA0..0xA3 -> at t=4: dout lanes = 0xA0..0xA3, dout_mask=4'hF, coll_err=0.
REQ-037 Scenario, row wrap: 10 back-to-back skewed beats -> 10 consecutive dout_valid cycles with dout_last only on the 10th; an 11th beat yields dout_last=0.
REQ-038 Scenario, collision: skewed beat at t=0, then aligned beat at t=1 with CB_en=4'hF -> lane 1 at t=1 goes to beat 0, beat 1 has dout_mask=4'hD, and coll_err=1.
REQ-039 Scenario, partial beat: skewed beat with CB_en[2] withheld at t=2 -> dout_mask=4'hB and lane 2 of dout = 0.
REQ-040 Scenario, reset mid-beat: sys_rst pulsed at t=2 of a skewed beat -> no dout_valid at t=4, busy=0 at t=3, and the row counter restarts at 0.
